fp_norm_round: RTL and testbench

FP_NORM_ROUND -- requirements
Module: fp_norm_round

---
 rtl/fp_norm_round.sv | 131 +++++++++++++
 tb/tb_fp_norm_round.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Normalise-and-round stage for a single-precision adder: left-normalises a raw
// 25-bit magnitude, rounds to nearest-even, and packs an IEEE-754 single.
module fp_norm_round (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [8:0]  in_exp,
   input  logic [24:0] in_mant,
   input  logic        in_sticky,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_overflow,
   output logic        out_underflow
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

   state_t      state, state_next;
   logic [24:0] m;
   logic [8:0]  e;
   logic        sgn;
   logic        stk;
   logic        unf;

   logic        m_zero;
   logic        norm_done;
   logic        unf_now;

   logic [22:0] f;
   logic        inc;
   logic [23:0] f_sum;
   logic [9:0]  e_rnd;
   logic [31:0] result;
   logic        result_ovf;

   // A zero exponent is always an underflow, even if the mantissa is already normal.
   always_comb begin
      m_zero    = (m == '0);
      unf_now   = !m_zero && ((e == 9'd0) || (!m[24] && (e == 9'd1)));
      norm_done = m_zero || m[24] || (e <= 9'd1);
   end

   // Round-to-nearest-even; a carry out of the fraction leaves f_sum[22:0] at zero.
   always_comb begin
      f          = m[23:1];
      inc        = m[0] && (stk || f[0]);
      f_sum      = {1'b0, f} + 24'(inc);
      e_rnd      = {1'b0, e} + 10'(f_sum[23]);
      result_ovf = 1'b0;
      if (m_zero) begin
         result = '0;
      end else if (unf) begin
         result = {sgn, 31'd0};
      end else if (e_rnd >= 10'd255) begin
         result     = {sgn, 8'hFF, 23'd0};
         result_ovf = 1'b1;
      end else begin
         result = {sgn, e_rnd[7:0], f_sum[22:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = NORM;
         NORM:    if (norm_done) state_next = ROUND;
         ROUND:                  state_next = OUT;
         OUT:     if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m             <= '0;
         e             <= '0;
         sgn           <= 1'b0;
         stk           <= 1'b0;
         unf           <= 1'b0;
         out_data      <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  m   <= in_mant;
                  e   <= in_exp;
                  sgn <= in_sign;
                  stk <= in_sticky;
                  unf <= 1'b0;
               end
            end
            NORM: begin
               if (!norm_done) begin
                  m <= {m[23:0], 1'b0};
                  e <= e - 9'd1;
               end else if (unf_now) begin
                  unf <= 1'b1;
               end
            end
            ROUND: begin
               out_data      <= result;
               out_overflow  <= result_ovf;
               out_underflow <= unf && !m_zero;
            end
            OUT: begin
               if (out_ready) begin
                  out_overflow  <= 1'b0;
                  out_underflow <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: driver pushes expected results, an
// independent monitor pops and compares whenever out_valid is presented.
module tb_fp_norm_round;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [8:0]  in_exp;
   logic [24:0] in_mant;
   logic        in_sticky;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_overflow;
   logic        out_underflow;

   fp_norm_round dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_overflow(out_overflow), .out_underflow(out_underflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   bit hold_low = 1'b0;

   typedef struct {
      logic [31:0] data;
      bit          ovf;
      bit          unf;
      int          lat;
      int          cap;
   } exp_t;

   exp_t q[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Value-level reference: leading-zero count, exponent budget, then RNE on integers.
   function automatic exp_t model(bit s, int e, bit [24:0] m, bit st);
      exp_t   r;
      int     k;
      int     ee;
      longint n;
      longint qq;
      r.data = '0; r.ovf = 0; r.unf = 0; r.cap = 0; r.lat = 2;
      if (m == 0) return r;
      k = 0;
      while (m[24-k] == 1'b0) k++;
      if (e <= k) begin
         r.unf  = 1;
         r.data = {s, 31'd0};
         r.lat  = e + 1;
         return r;
      end
      r.lat = k + 2;
      n  = longint'(m) << k;
      qq = n >>> 1;
      if ((n & 1) != 0 && (st || (qq & 1) != 0)) qq++;
      ee = e - k;
      if (qq == (64'd1 << 24)) begin
         ee++;
         qq = 64'd1 << 23;
      end
      if (ee >= 255) begin
         r.ovf  = 1;
         r.data = {s, 8'hFF, 23'd0};
      end else begin
         r.data = {s, 8'(ee), 23'(qq)};
      end
      return r;
   endfunction

   task automatic send(bit s, bit [8:0] e, bit [24:0] m, bit st, exp_t x);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=in_ready=0 required=1");
         in_valid = 1'b0;
         return;
      end
      x.cap = cyc + 1;
      q.push_back(x);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_m(bit s, bit [8:0] e, bit [24:0] m, bit st);
      send(s, e, m, st, model(s, int'(e), m, st));
   endtask

   task automatic send_d(bit s, bit [8:0] e, bit [24:0] m, bit st,
                         logic [31:0] d, bit ovf, bit unf, int lat);
      exp_t x;
      x.data = d; x.ovf = ovf; x.unf = unf; x.lat = lat; x.cap = 0;
      send(s, e, m, st, x);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         checks++; failures++;
         $display("FAIL valid_timeout actual=out_valid=0 required=1");
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || out_valid) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=pending=%0d required=0", q.size());
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_in_ready"},  32'(in_ready),      32'd1);
      check({tag, "_out_valid"}, 32'(out_valid),     32'd0);
      check({tag, "_out_data"},  out_data,           32'd0);
      check({tag, "_ovf"},       32'(out_overflow),  32'd0);
      check({tag, "_unf"},       32'(out_underflow), 32'd0);
   endtask

   // Consumer: random backpressure unless a directed test pins it low.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops once per presented result, then checks it holds until released.
   initial begin
      bit   seen = 0;
      exp_t cur;
      forever begin
         @(negedge clk);
         if (!out_valid) begin
            seen = 0;
            check("idle_ovf", 32'(out_overflow),  32'd0);
            check("idle_unf", 32'(out_underflow), 32'd0);
         end else if (!seen) begin
            seen = 1;
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
               cur = q.pop_front();
               check("data",      out_data,            cur.data);
               check("overflow",  32'(out_overflow),   32'(cur.ovf));
               check("underflow", 32'(out_underflow),  32'(cur.unf));
               check("latency",   32'(cyc - cur.cap),  32'(cur.lat));
            end
         end else begin
            check("hold_data", out_data,          cur.data);
            check("hold_ovf",  32'(out_overflow),  32'(cur.ovf));
            check("hold_unf",  32'(out_underflow), 32'(cur.unf));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t x;
      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0;
      #2 check_reset_outputs("por");
      repeat (3) @(negedge clk);
      rst = 1'b0;

      send_d(0, 9'd128, 25'h1800000, 0, 32'h40400000, 0, 0, 2);
      send_d(0, 9'd128, 25'h0800000, 0, 32'h3F800000, 0, 0, 3);
      send_d(0, 9'd127, 25'h1000001, 0, 32'h3F800000, 0, 0, 2);
      send_d(0, 9'd127, 25'h1000003, 0, 32'h3F800002, 0, 0, 2);
      send_d(0, 9'd127, 25'h1000001, 1, 32'h3F800001, 0, 0, 2);
      send_d(0, 9'd254, 25'h1FFFFFF, 0, 32'h7F800000, 1, 0, 2);
      send_d(1, 9'd254, 25'h1FFFFFF, 0, 32'hFF800000, 1, 0, 2);
      send_d(1, 9'd128, 25'h0000000, 0, 32'h00000000, 0, 0, 2);
      send_d(0, 9'd2,   25'h0000100, 0, 32'h00000000, 0, 1, 3);
      send_d(1, 9'd1,   25'h0400000, 0, 32'h80000000, 0, 1, 2);
      wait_drain();

      // Backpressure: result and in_ready must stay put for five stalled cycles.
      hold_low = 1'b1;
      send_d(0, 9'd128, 25'h1800000, 0, 32'h40400000, 0, 0, 2);
      wait_valid();
      repeat (5) begin
         @(negedge clk);
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready),  32'd0);
         check("bp_data",     out_data,       32'h40400000);
      end
      hold_low = 1'b0;
      wait_drain();

      // Reset mid-NORM on a 24-shift operand.
      send_d(0, 9'd100, 25'h0000001, 0, 32'h0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_norm");
      q.delete();
      @(negedge clk);
      #2 rst = 1'b0;

      // Reset while a result is stalled in OUT.
      hold_low = 1'b1;
      send_d(1, 9'd127, 25'h1000003, 0, 32'hBF800002, 0, 0, 2);
      wait_valid();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_out");
      q.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      hold_low = 1'b0;

      send_d(0, 9'd128, 25'h0800000, 0, 32'h3F800000, 0, 0, 3);
      wait_drain();

      for (int i = 0; i < 150; i++) begin
         bit [8:0]  e;
         bit [24:0] m;
         int        p;
         int        sel = $urandom_range(0, 2);
         e = (sel == 0) ? 9'($urandom_range(1, 30)) :
             (sel == 1) ? 9'($urandom_range(31, 239)) : 9'($urandom_range(240, 300));
         p = $urandom_range(0, 24);
         m = 25'((32'd1 << p) | ($urandom & ((32'd1 << p) - 32'd1)));
         if ($urandom_range(0, 19) == 0) m = '0;
         send_m(1'($urandom), e, m, 1'($urandom));
      end
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
